// File: rtl/wind_defs.sv
// Shared angle constants and averager state encoding.
// The rect-to-polar wind path uses the same angle constants.
package wind_defs;

  localparam logic signed [15:0] DEG180_9Q7 = 16'sd23040;
  localparam logic signed [16:0] DEG360_9Q7 = 17'sd46080;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_ACCUM_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ACCUM = ST_ACCUM_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_e;

endpackage

// File: rtl/wind_angle_wrap.sv
// Folds a signed 9Q7 angle into (-180, +180] degrees.
// The input must lie within (-540, +540] degrees, so one fold suffices.
module wind_angle_wrap
  import wind_defs::*;
#(
  parameter int W = 18
) (
  input  logic signed [W-1:0] ang_i,
  output logic signed [15:0]  ang_o
);

  localparam logic signed [W-1:0] HALF = W'(DEG180_9Q7);
  localparam logic signed [W-1:0] FULL = W'(DEG360_9Q7);

  logic signed [W-1:0] t;

  // -180 itself folds up to +180 so the range is half-open at the bottom
  always_comb begin
    t = ang_i;
    if (ang_i > HALF) begin
      t = ang_i - FULL;
    end else if (ang_i <= -HALF) begin
      t = ang_i + FULL;
    end
  end

  assign ang_o = 16'(t);

endmodule

// File: rtl/wind_avg.sv
// Windowed mean speed / gust / wrap-aware mean direction over 2**LOG2N samples.
// Define WIND_GUST_EN to track the per-window peak speed on gust_speed.
module wind_avg
  import wind_defs::*;
#(
  parameter int LOG2N = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [15:0]        speed,
  input  logic signed [15:0] direction,
  output logic [15:0]        avg_speed,
  output logic [15:0]        gust_speed,
  output logic signed [15:0] avg_direction,
  output logic               out_valid,
  output logic [LOG2N:0]     sample_cnt
);

  localparam int N  = 1 << LOG2N;
  localparam int CW = LOG2N + 1;
  localparam int SW = 16 + LOG2N;
  localparam int DW = 17 + LOG2N;

  state_e               state_q, state_d;
  logic signed [15:0]   ref_dir_q, ref_dir_d;
  logic [SW-1:0]        acc_spd_q, acc_spd_d;
  logic signed [DW-1:0] acc_dlt_q, acc_dlt_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [15:0]          avg_spd_q, avg_spd_d;
  logic signed [15:0]   avg_dir_q, avg_dir_d;
  logic                 out_valid_q, out_valid_d;

  logic                 take_first;
  logic                 acc_en;
  logic                 drop;

  logic signed [17:0]   dir_x;
  logic signed [17:0]   ref_x;
  logic signed [15:0]   dlt_fold;
  logic signed [16:0]   dlt_mean;
  logic signed [17:0]   dir_sum;
  logic signed [15:0]   dir_fold;

  assign dir_x = {{2{direction[15]}}, direction};
  assign ref_x = {{2{ref_dir_q[15]}}, ref_dir_q};

  // Deltas are taken against the window's first angle so +/-180 crossings average correctly
  wind_angle_wrap #(.W(18)) u_dlt_fold (
    .ang_i (dir_x - ref_x),
    .ang_o (dlt_fold)
  );

  assign dlt_mean = 17'(acc_dlt_q >>> LOG2N);
  assign dir_sum  = ref_x + {dlt_mean[16], dlt_mean};

  wind_angle_wrap #(.W(18)) u_out_fold (
    .ang_i (dir_sum),
    .ang_o (dir_fold)
  );

  // Next-state: window bookkeeping, and output capture in the DONE cycle
  always_comb begin
    state_d     = state_q;
    ref_dir_d   = ref_dir_q;
    acc_spd_d   = acc_spd_q;
    acc_dlt_d   = acc_dlt_q;
    cnt_d       = cnt_q;
    avg_spd_d   = avg_spd_q;
    avg_dir_d   = avg_dir_q;
    out_valid_d = 1'b0;
    take_first  = 1'b0;
    acc_en      = 1'b0;
    drop        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        take_first = in_valid && !clear;
      end
      ST_ACCUM: begin
        if (clear) begin
          drop = 1'b1;
        end else if (in_valid) begin
          acc_en    = 1'b1;
          acc_spd_d = acc_spd_q + {{LOG2N{1'b0}}, speed};
          acc_dlt_d = acc_dlt_q + {{(DW-16){dlt_fold[15]}}, dlt_fold};
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        avg_spd_d   = 16'(acc_spd_q >> LOG2N);
        avg_dir_d   = dir_fold;
        out_valid_d = 1'b1;
        if (in_valid && !clear) begin
          take_first = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
      default: begin
        drop = 1'b1;
      end
    endcase

    if (take_first) begin
      state_d   = ST_ACCUM;
      ref_dir_d = direction;
      acc_spd_d = {{LOG2N{1'b0}}, speed};
      acc_dlt_d = '0;
      cnt_d     = CW'(1);
    end

    if (drop) begin
      state_d   = ST_IDLE;
      acc_spd_d = '0;
      acc_dlt_d = '0;
      cnt_d     = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ref_dir_q   <= '0;
      acc_spd_q   <= '0;
      acc_dlt_q   <= '0;
      cnt_q       <= '0;
      avg_spd_q   <= '0;
      avg_dir_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_dir_q   <= ref_dir_d;
      acc_spd_q   <= acc_spd_d;
      acc_dlt_q   <= acc_dlt_d;
      cnt_q       <= cnt_d;
      avg_spd_q   <= avg_spd_d;
      avg_dir_q   <= avg_dir_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef WIND_GUST_EN
  logic [15:0] gmax_q, gmax_d;
  logic [15:0] gust_q, gust_d;

  // Running peak: first sample seeds it, published with the averages
  always_comb begin
    gmax_d = gmax_q;
    gust_d = gust_q;
    if (state_q == ST_DONE) begin
      gust_d = gmax_q;
    end
    if (take_first) begin
      gmax_d = speed;
    end else if (acc_en && (speed > gmax_q)) begin
      gmax_d = speed;
    end
  end

  // Peak registers
  always_ff @(posedge clock) begin
    if (reset) begin
      gmax_q <= '0;
      gust_q <= '0;
    end else begin
      gmax_q <= gmax_d;
      gust_q <= gust_d;
    end
  end

  assign gust_speed = gust_q;
`else
  assign gust_speed = 16'd0;
`endif

  assign avg_speed     = avg_spd_q;
  assign avg_direction = avg_dir_q;
  assign out_valid     = out_valid_q;
  assign sample_cnt    = cnt_q;

endmodule
